// File: rtl/trace_formatter_pkg.sv
// Shared definitions for the trace formatter: snapshot layout, line geometry,
// ASCII constants and formatter state encodings.
package trace_formatter_pkg;

  localparam int unsigned LINE_LEN = 35;
  localparam int unsigned SNAP_W   = 97;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_NL    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h61;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic        halted;
    logic [15:0] pc;
    logic [15:0] sp;
    logic [15:0] af;
    logic [15:0] bc;
    logic [15:0] de;
    logic [15:0] hl;
  } snapshot_t;

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO; the extra pointer bit tells full from empty.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/trace_formatter.sv
// Captures a register snapshot on each instruction retire and streams it out
// as a 35-byte ASCII trace line over a valid/ready byte interface.
module trace_formatter
  import trace_formatter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dbg_pc,
  input  logic [15:0] dbg_sp,
  input  logic [15:0] dbg_AF,
  input  logic [15:0] dbg_BC,
  input  logic [15:0] dbg_DE,
  input  logic [15:0] dbg_HL,
  input  logic        dbg_instruction_retired,
  input  logic        dbg_halted,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        trace_done
);

  logic              ret_q;
  logic              stop_capture;
  logic              capture;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              hs;
  logic [1:0]        state;
  logic [5:0]        idx;
  snapshot_t         wr_snap;
  snapshot_t         line;
  logic [SNAP_W-1:0] head_bits;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_ZERO + {4'h0, n} : ASCII_A + {4'h0, n} - 8'd10;
  endfunction

  // Columns of five bytes: four hex digits and a space per register.
  function automatic logic [7:0] line_byte(input snapshot_t s, input logic [5:0] i);
    logic [15:0] field;
    logic [2:0]  grp;
    logic [2:0]  pos;
    logic [3:0]  nib;
    grp = 3'(i / 6'd5);
    pos = 3'(i % 6'd5);
    case (grp)
      3'd0:    field = s.pc;
      3'd1:    field = s.sp;
      3'd2:    field = s.af;
      3'd3:    field = s.bc;
      3'd4:    field = s.de;
      default: field = s.hl;
    endcase
    case (pos)
      3'd0:    nib = field[15:12];
      3'd1:    nib = field[11:8];
      3'd2:    nib = field[7:4];
      default: nib = field[3:0];
    endcase
    if (i == 6'd34)      return ASCII_NL;
    else if (i >= 6'd30) return ASCII_ZERO + {7'h0, s.af[4'(6'd37 - i)]};
    else if (pos == 3'd4) return ASCII_SPACE;
    else                 return hex_ascii(nib);
  endfunction

  assign capture = dbg_instruction_retired && !ret_q && !stop_capture;
  assign pop     = (state == ST_IDLE) && !fifo_empty;
  assign hs      = out_valid && out_ready;

  always_comb begin
    wr_snap        = '0;
    wr_snap.halted = dbg_halted;
    wr_snap.pc     = dbg_pc;
    wr_snap.sp     = dbg_sp;
    wr_snap.af     = dbg_AF;
    wr_snap.bc     = dbg_BC;
    wr_snap.de     = dbg_DE;
    wr_snap.hl     = dbg_HL;
  end

  trace_fifo #(
    .WIDTH(SNAP_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (capture),
    .pop    (pop),
    .wr_data(wr_snap),
    .rd_data(head_bits),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_q        <= 1'b0;
      stop_capture <= 1'b0;
      overflow     <= 1'b0;
      state        <= ST_IDLE;
      idx          <= '0;
      line         <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      trace_done   <= 1'b0;
    end else begin
      ret_q <= dbg_instruction_retired;
      if (capture) begin
        if (fifo_full)       overflow     <= 1'b1;
        else if (dbg_halted) stop_capture <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            line      <= head_bits;
            idx       <= '0;
            out_data  <= line_byte(head_bits, 6'd0);
            out_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (hs) begin
            if (idx == 6'(LINE_LEN - 1)) begin
              out_valid <= 1'b0;
              if (line.halted) begin
                state      <= ST_DONE;
                trace_done <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              idx      <= idx + 6'd1;
              out_data <= line_byte(line, idx + 6'd1);
            end
          end
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_formatter.sv
// Directed bench for trace_formatter: hand-computed trace lines checked byte by byte.
module tb_trace_formatter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dbg_pc, dbg_sp, dbg_AF, dbg_BC, dbg_DE, dbg_HL;
  logic        dbg_instruction_retired;
  logic        dbg_halted;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        trace_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trace_formatter #(.FIFO_DEPTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .dbg_pc                 (dbg_pc),
    .dbg_sp                 (dbg_sp),
    .dbg_AF                 (dbg_AF),
    .dbg_BC                 (dbg_BC),
    .dbg_DE                 (dbg_DE),
    .dbg_HL                 (dbg_HL),
    .dbg_instruction_retired(dbg_instruction_retired),
    .dbg_halted             (dbg_halted),
    .out_data               (out_data),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .overflow               (overflow),
    .trace_done             (trace_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_snap(input logic h, input logic [15:0] pc, sp, af, bc, de, hl);
    dbg_halted = h;
    dbg_pc = pc; dbg_sp = sp; dbg_AF = af;
    dbg_BC = bc; dbg_DE = de; dbg_HL = hl;
  endtask

  task automatic retire_pulse();
    dbg_instruction_retired = 1'b1;
    tick();
    dbg_instruction_retired = 1'b0;
  endtask

  task automatic get_line(input string exp, input int nbytes, input bit toggle,
                          input string tag, output int cycles);
    int i;
    logic [7:0] held;
    i = 0;
    cycles = 0;
    while (i < nbytes && cycles < 500) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("%s byte %0d", tag, i), {24'h0, out_data}, {24'h0, exp[i]});
        i++;
        tick();
      end else if (out_valid) begin
        held = out_data;
        tick();
        check($sformatf("%s stall at %0d", tag, i), {23'h0, out_valid, out_data}, {23'h0, 1'b1, held});
      end else begin
        tick();
      end
      cycles++;
    end
    if (i < nbytes) check($sformatf("%s timeout bytes", tag), i, nbytes);
  endtask

  task automatic quiet(input int n, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      if (out_valid) seen++;
      tick();
    end
    check(tag, seen, 0);
  endtask

  initial begin
    string l1, lb, lh, lo;
    int cyc;
    l1 = "0150 fffe 01b0 0013 00d8 014d 1011\n";
    lb = "1234 abcd 5a70 9f00 cafe beef 0111\n";
    lh = "00aa fffe 8010 0000 0000 0000 0001\n";

    reset = 1'b1;
    dbg_instruction_retired = 1'b0;
    out_ready = 1'b0;
    set_snap(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    tick(); tick();
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset overflow", overflow, 0);
    check("reset trace_done", trace_done, 0);
    reset = 1'b0;
    tick();

    // Single line, ready held high: latency then 35 back-to-back bytes
    set_snap(1'b0, 16'h0150, 16'hFFFE, 16'h01B0, 16'h0013, 16'h00D8, 16'h014D);
    out_ready = 1'b1;
    retire_pulse();
    check("latency no valid yet", out_valid, 0);
    tick();
    check("latency valid", out_valid, 1);
    check("latency byte0", out_data, 8'h30);
    get_line(l1, 35, 1'b0, "single", cyc);
    check("single cycles", cyc, 35);
    check("single valid after", out_valid, 0);
    quiet(10, "single no extra");

    // Same snapshot with ready toggling
    retire_pulse();
    get_line(l1, 35, 1'b1, "toggle", cyc);
    out_ready = 1'b1;
    quiet(10, "toggle no extra");

    // Retire level held 10 cycles yields one line
    set_snap(1'b0, 16'h1234, 16'hABCD, 16'h5A70, 16'h9F00, 16'hCAFE, 16'hBEEF);
    out_ready = 1'b0;
    dbg_instruction_retired = 1'b1;
    repeat (10) tick();
    dbg_instruction_retired = 1'b0;
    get_line(lb, 35, 1'b0, "held", cyc);
    quiet(40, "held single line");

    // Six retires with sink stalled: line register plus four FIFO slots hold five
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_snap(1'b0, 16'(k), 16'h1111, 16'h00F0, 16'h2222, 16'h3333, 16'h4444);
      retire_pulse();
      tick();
      if (k == 5) check("overflow before sixth", overflow, 0);
    end
    check("overflow set", overflow, 1);
    for (int k = 1; k <= 5; k++) begin
      lo = $sformatf("%04h 1111 00f0 2222 3333 4444 1111\n", 16'(k));
      get_line(lo, 35, 1'b0, $sformatf("ovf line %0d", k), cyc);
    end
    quiet(40, "ovf sixth dropped");
    check("overflow sticky", overflow, 1);

    // Reset in the middle of a line
    set_snap(1'b0, 16'h1234, 16'hABCD, 16'h5A70, 16'h9F00, 16'hCAFE, 16'hBEEF);
    retire_pulse();
    get_line(lb, 12, 1'b0, "partial", cyc);
    check("partial still valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("async out_valid", out_valid, 0);
    check("async out_data", out_data, 0);
    check("async overflow", overflow, 0);
    check("async trace_done", trace_done, 0);
    tick();
    reset = 1'b0;
    tick();
    quiet(5, "no resume");
    set_snap(1'b0, 16'h0150, 16'hFFFE, 16'h01B0, 16'h0013, 16'h00D8, 16'h014D);
    retire_pulse();
    get_line(l1, 35, 1'b0, "after reset", cyc);

    // Halted line then terminal
    out_ready = 1'b0;
    check("done before halt", trace_done, 0);
    set_snap(1'b1, 16'h00AA, 16'hFFFE, 16'h8010, 16'h0000, 16'h0000, 16'h0000);
    retire_pulse();
    tick();
    set_snap(1'b0, 16'h1234, 16'hABCD, 16'h5A70, 16'h9F00, 16'hCAFE, 16'hBEEF);
    retire_pulse();
    tick();
    get_line(lh, 35, 1'b0, "halted", cyc);
    check("trace_done set", trace_done, 1);
    check("done valid low", out_valid, 0);
    quiet(40, "no bytes after halt");
    check("trace_done sticky", trace_done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
